adc_decimator: RTL and testbench
================================

ADC_DECIMATOR -- requirements
Module: adc_decimator

Interface
REQ-001 Parameter bits, default 14, width of each two's-complement ADC sample and averaged output.
REQ-002 Parameter max_log2_dec, default 10, largest log2 decimation ratio supported.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset; asserts immediately, releases synchronously to clk.
REQ-005 adc_a_i  input  bits  channel A sample, signed two's complement, from the ADC 2's-complement conversion stage.
REQ-006 adc_b_i  input  bits  channel B sample, signed two's complement.
REQ-007 en_i  input  1  1 = accumulate a sample every clk; 0 = abort window, hold outputs.
REQ-008 dec_sel_i  input  4  log2 decimation ratio N = 2^dec_sel_i.
REQ-009 avg_a_o  output  bits  signed window average, channel A.
REQ-010 avg_b_o  output  bits  signed window average, channel B.
REQ-011 valid_o  output  1  single-cycle strobe marking new avg_a_o/avg_b_o.
REQ-012 sat_a_o  output  1  channel A hit full scale during the reported window.
REQ-013 sat_b_o  output  1  channel B hit full scale during the reported window.

Function
REQ-014 Two states SHALL exist: IDLE (en_i=0) and ACC (en_i=1); IDLE->ACC when en_i samples 1, ACC->IDLE when en_i samples 0.
REQ-015 In ACC, one sample per channel SHALL be accumulated every rising edge; no gap cycles between consecutive windows.
REQ-016 Effective ratio d SHALL be min(dec_sel_i, max_log2_dec), latched at the first sample of each window; changes mid-window apply to the next window only.
REQ-017 Accumulators SHALL be signed, bits+max_log2_dec wide (24 by default); no overflow possible.
REQ-018 Window sample counter SHALL count 0..2^d-1 and wrap to 0 after the last sample.
REQ-019 On the edge capturing the last sample of a window, avg_x_o SHALL load (acc_x + sample_x) arithmetically shifted right by d (floor toward minus infinity), and valid_o SHALL be 1 for the following cycle only.
REQ-020 On that same edge accumulators SHALL clear so the next sample starts a new window.
REQ-021 Latency: avg_x_o/valid_o update 1 clk after the window's last sample is presented; d=0 gives pass-through with 1-cycle latency and valid_o high every cycle.
REQ-022 sat_x_o SHALL be 1 if any sample of the reported window equalled 2^(bits-1)-1 or -2^(bits-1); it updates only with valid_o.
REQ-023 avg_x_o and sat_x_o SHALL hold their values between valid_o strobes.
REQ-024 en_i dropping mid-window SHALL discard the partial window (counter, accumulators, saturation trackers cleared), produce no valid_o, and keep outputs unchanged.
REQ-025 en_i rising SHALL start a fresh window with the sample present on that edge.

Reset
REQ-026 While rst=1: avg_a_o=0, avg_b_o=0, valid_o=0, sat_a_o=0, sat_b_o=0, counter=0, accumulators=0, latched d=0, state IDLE.
REQ-027 Reset asserted mid-window SHALL discard the window with no valid_o; after release, accumulation restarts at the first edge with en_i=1.

Verification
REQ-028 d=2, en_i=1, A = 4,8,12,16 repeating -> valid_o every 4th cycle, avg_a_o=10 each time, no idle gap between windows.
REQ-029 d=1, B = -3,-2 -> avg_b_o=-3 (floor of -2.5); B = 3,2 -> avg_b_o=2.
REQ-030 d=0, A ramps 0,1,2,... -> valid_o continuous, avg_a_o equals input delayed 1 cycle.
REQ-031 d=3, A includes one sample 8191 in window -> sat_a_o=1 with that window's valid_o, 0 for the next clean window.
REQ-032 d=2, en_i deasserted after 2 samples, reasserted -> no valid_o for the aborted window; next valid_o after 4 fresh samples; dec_sel_i changed 2->4 mid-window -> current window completes at 4 samples, next at 16.
REQ-033 rst pulsed mid-window (asynchronous to clk) -> all outputs 0 immediately, no valid_o from partial window, dec_sel_i=15 after release -> windows of 1024 samples.

Source files
------------

// File: rtl/adc_decimator.sv
// Dual-channel ADC decimator: averages 2^d consecutive signed samples per channel
// and reports the window mean with a one-cycle valid strobe and full-scale flags.
module adc_decimator #(
   parameter int unsigned bits         = 14,
   parameter int unsigned max_log2_dec = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic signed [bits-1:0] adc_a_i,
   input  logic signed [bits-1:0] adc_b_i,
   input  logic                   en_i,
   input  logic [3:0]             dec_sel_i,
   output logic signed [bits-1:0] avg_a_o,
   output logic signed [bits-1:0] avg_b_o,
   output logic                   valid_o,
   output logic                   sat_a_o,
   output logic                   sat_b_o
);

   localparam int unsigned AW = bits + max_log2_dec;
   localparam int unsigned CW = (max_log2_dec > 0) ? max_log2_dec : 1;
   localparam int unsigned DW = (max_log2_dec > 0) ? $clog2(max_log2_dec + 1) : 1;
   localparam logic signed [bits-1:0] FS_POS = {1'b0, {(bits-1){1'b1}}};
   localparam logic signed [bits-1:0] FS_NEG = {1'b1, {(bits-1){1'b0}}};

   typedef enum logic {IDLE, ACC} state_t;

   state_t               state, next_state;
   logic signed [AW-1:0] acc_a, acc_b;
   logic [CW-1:0]        cnt;
   logic [DW-1:0]        d_lat;
   logic                 trk_a, trk_b;

   logic [DW-1:0]        d_sel_c, d_eff_c;
   logic                 start_c, last_c, hit_a_c, hit_b_c;
   logic signed [AW-1:0] sum_a_c, sum_b_c, shr_a_c, shr_b_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (en_i)  next_state = ACC;
         ACC:     if (!en_i) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Ratio is frozen at the first sample of a window; that sample already uses it.
   always_comb begin
      d_sel_c = (32'(dec_sel_i) > max_log2_dec) ? DW'(max_log2_dec) : DW'(dec_sel_i);
      start_c = (state == IDLE) || (cnt == '0);
      d_eff_c = start_c ? d_sel_c : d_lat;
      last_c  = (cnt == CW'((32'd1 << d_eff_c) - 32'd1));
      sum_a_c = acc_a + AW'(adc_a_i);
      sum_b_c = acc_b + AW'(adc_b_i);
      shr_a_c = sum_a_c >>> d_eff_c;
      shr_b_c = sum_b_c >>> d_eff_c;
      hit_a_c = (adc_a_i == FS_POS) || (adc_a_i == FS_NEG);
      hit_b_c = (adc_b_i == FS_POS) || (adc_b_i == FS_NEG);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_a   <= '0;
         acc_b   <= '0;
         cnt     <= '0;
         d_lat   <= '0;
         trk_a   <= 1'b0;
         trk_b   <= 1'b0;
         avg_a_o <= '0;
         avg_b_o <= '0;
         valid_o <= 1'b0;
         sat_a_o <= 1'b0;
         sat_b_o <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         if (en_i) begin
            d_lat <= d_eff_c;
            if (last_c) begin
               avg_a_o <= shr_a_c[bits-1:0];
               avg_b_o <= shr_b_c[bits-1:0];
               sat_a_o <= trk_a | hit_a_c;
               sat_b_o <= trk_b | hit_b_c;
               valid_o <= 1'b1;
               acc_a   <= '0;
               acc_b   <= '0;
               cnt     <= '0;
               trk_a   <= 1'b0;
               trk_b   <= 1'b0;
            end else begin
               acc_a <= sum_a_c;
               acc_b <= sum_b_c;
               cnt   <= cnt + CW'(1);
               trk_a <= trk_a | hit_a_c;
               trk_b <= trk_b | hit_b_c;
            end
         end else begin
            // Disable discards the partial window; reported outputs hold.
            acc_a <= '0;
            acc_b <= '0;
            cnt   <= '0;
            trk_a <= 1'b0;
            trk_b <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_adc_decimator.sv
// Directed, table-driven bench for adc_decimator with hand-written multi-cycle sequences.
module tb_adc_decimator;

   logic              clk = 1'b0;
   logic              rst;
   logic signed [13:0] adc_a, adc_b, avg_a, avg_b;
   logic              en, valid, sat_a, sat_b;
   logic [3:0]        dec_sel;

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      int en, d, a, b;
      int valid, avg_a, avg_b, sat_a, sat_b;
   } vec_t;
   vec_t vq[$];

   adc_decimator #(.bits(14), .max_log2_dec(10)) dut (
      .clk(clk), .rst(rst), .adc_a_i(adc_a), .adc_b_i(adc_b), .en_i(en),
      .dec_sel_i(dec_sel), .avg_a_o(avg_a), .avg_b_o(avg_b), .valid_o(valid),
      .sat_a_o(sat_a), .sat_b_o(sat_b));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int e, input int d, input int a, input int b);
      en = 1'(e);
      dec_sel = 4'(d);
      adc_a = 14'(a);
      adc_b = 14'(b);
   endtask

   task automatic add(input int e, input int d, input int a, input int b, input int v,
                      input int xa, input int xb, input int sa, input int sb);
      vec_t r;
      r.en = e; r.d = d; r.a = a; r.b = b;
      r.valid = v; r.avg_a = xa; r.avg_b = xb; r.sat_a = sa; r.sat_b = sb;
      vq.push_back(r);
   endtask

   task automatic chk_out(input string tag, input int v, input int xa, input int xb,
                          input int sa, input int sb);
      chk({tag, "_valid"}, int'(valid), v);
      chk({tag, "_avg_a"}, int'(avg_a), xa);
      chk({tag, "_avg_b"}, int'(avg_b), xb);
      chk({tag, "_sat_a"}, int'(sat_a), sa);
      chk({tag, "_sat_b"}, int'(sat_b), sb);
   endtask

   initial begin
      int early;

      // d=2, A = 4,8,12,16 repeating: mean 10 every fourth sample, back to back
      for (int k = 0; k < 8; k++)
         add(1, 2, 4 * (k % 4 + 1), 0, int'(k % 4 == 3), (k >= 3) ? 10 : 0, 0, 0, 0);
      // d=1 floor rounding on negative and positive pairs
      add(1, 1, 0, -3, 0, 10, 0, 0, 0);
      add(1, 1, 0, -2, 1, 0, -3, 0, 0);
      add(1, 1, 0,  3, 0, 0, -3, 0, 0);
      add(1, 1, 0,  2, 1, 0,  2, 0, 0);
      // d=0 pass-through with one cycle latency
      for (int k = 0; k < 6; k++)
         add(1, 0, k, -k, 1, k, -k, 0, 0);
      // d=3: positive full scale on A in first window, negative full scale on B in second
      for (int k = 0; k < 8; k++)
         add(1, 3, (k == 0) ? 8191 : ((k == 7) ? 1 : 0), 0, int'(k == 7),
             (k == 7) ? 1024 : 5, (k == 7) ? 0 : -5, int'(k == 7), 0);
      for (int k = 0; k < 8; k++)
         add(1, 3, 2, (k == 0) ? -8192 : 0, int'(k == 7),
             (k == 7) ? 2 : 1024, (k == 7) ? -1024 : 0, (k == 7) ? 0 : 1, int'(k == 7));

      rst = 1'b1;
      drive(0, 0, 0, 0);
      #12;
      chk_out("reset", 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vq[i]) begin
         drive(vq[i].en, vq[i].d, vq[i].a, vq[i].b);
         step();
         chk_out($sformatf("vec%0d", i), vq[i].valid, vq[i].avg_a, vq[i].avg_b,
                 vq[i].sat_a, vq[i].sat_b);
      end

      // Abort after two samples: no strobe, outputs hold, fresh window afterwards
      for (int k = 0; k < 2; k++) begin
         drive(1, 2, 100, 0);
         step();
         chk($sformatf("abort_pre%0d_valid", k), int'(valid), 0);
      end
      drive(0, 2, 100, 0);
      step();
      chk_out("abort_idle", 0, 2, -1024, 0, 1);
      for (int k = 0; k < 4; k++) begin
         drive(1, 2, 40, -40);
         step();
         chk($sformatf("fresh%0d_valid", k), int'(valid), int'(k == 3));
      end
      chk_out("fresh_done", 1, 40, -40, 0, 0);

      // Ratio change mid-window only affects the next window
      for (int k = 0; k < 4; k++) begin
         drive(1, (k == 0) ? 2 : 4, 8, 8);
         step();
         chk($sformatf("dchg%0d_valid", k), int'(valid), int'(k == 3));
      end
      chk("dchg_avg_a", int'(avg_a), 8);
      early = 0;
      for (int k = 0; k < 16; k++) begin
         drive(1, 4, 16, -16);
         step();
         if (k < 15 && valid) early++;
      end
      chk("d4_early_valid", early, 0);
      chk_out("d4_done", 1, 16, -16, 0, 0);

      // Asynchronous reset in the middle of a window
      for (int k = 0; k < 5; k++) begin
         drive(1, 4, 1000, 5);
         step();
      end
      #2;
      rst = 1'b1;
      #1;
      chk_out("async_rst", 0, 0, 0, 0, 0);
      drive(0, 15, 0, 0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         step();
         chk($sformatf("post_rst%0d_valid", k), int'(valid), 0);
      end

      // dec_sel=15 clamps to 1024-sample windows
      early = 0;
      for (int k = 0; k < 1024; k++) begin
         drive(1, 15, 7, -7);
         step();
         if (k < 1023 && valid) early++;
         if (k == 1022) chk("w1024_hold_avg_a", int'(avg_a), 0);
      end
      chk("w1024_early_valid", early, 0);
      chk_out("w1024_done", 1, 7, -7, 0, 0);
      drive(1, 15, 7, -7);
      step();
      chk("w1024_strobe_single", int'(valid), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
